seg7_digit_monitor: RTL

Receive-side checker for the seven-segment digit stream produced by the team's 0-9 display counter. It samples the active-low segment bus and filters out transient patterns. It decodes each stable pattern back to a 4-bit digit and verifies that successive digits follow the 0,1,...,9,0 sequence. It sits beside the display driver, either on the board or in a self-checking harness, and raises pulses and counters for a host or an LED to consume.

---
 rtl/seg7_pkg.sv | 32 +++
 rtl/seg7_to_hex.sv | 32 +++
 rtl/seg7_digit_monitor.sv | 122 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment digit monitor.
//   SEG_DIGIT[0:9] - active-low segment patterns (bit 6 = a ... bit 0 = g)
//   SEG_BLANK      - all segments dark
//   state_t        - monitor FSM states
//   next_digit()   - decimal successor with 9 wrapping to 0
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100   // 9
  };

  typedef enum logic {
    SYNC   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic logic [3:0] next_digit(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// seg7_to_hex: combinational decode of an active-low segment pattern.
//   seg      in  7  segment pattern, bit 6 = a ... bit 0 = g, 0 = lit
//   hex      out 4  decoded digit (0 when not a digit)
//   is_digit out 1  pattern is one of the ten digit glyphs
//   is_blank out 1  pattern has every segment dark
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] hex,
  output logic       is_digit,
  output logic       is_blank
);

  logic [9:0] match;

  for (genvar gi = 0; gi < 10; gi++) begin : g_match
    assign match[gi] = (seg == SEG_DIGIT[gi]);
  end

  // The glyphs are all distinct, so at most one match bit is set.
  always_comb begin
    hex      = 4'd0;
    is_digit = |match;
    for (int i = 0; i < 10; i++) begin
      if (match[i]) hex = 4'(i);
    end
  end

  assign is_blank = (seg == SEG_BLANK);

endmodule

// File: rtl/seg7_digit_monitor.sv
// seg7_digit_monitor: checks a seven-segment digit stream for 0..9,0 order.
//   clk          in  1      system clock
//   rst          in  1      synchronous active-high reset
//   seg          in  7      active-low segment bus (bit 6 = a ... bit 0 = g)
//   digit        out 4      last accepted digit
//   digit_valid  out 1      pulse: new valid digit accepted
//   invalid      out 1      pulse: stable pattern is neither digit nor blank
//   seq_error    out 1      pulse: accepted digit is not predecessor + 1
//   locked       out 1      a predecessor digit is held for checking
//   digit_cnt    out CNT_W  accepted digits, saturating
//   err_cnt      out CNT_W  sequence errors, saturating
module seg7_digit_monitor
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             invalid,
  output logic             seq_error,
  output logic             locked,
  output logic [CNT_W-1:0] digit_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);

  logic [6:0]       s_q_reg;
  logic [6:0]       s_prev_reg;
  logic [STAB_W-1:0] stab_cnt_reg;
  logic [STAB_W-1:0] stab_cnt_next;
  logic [6:0]       last_acc_reg;
  state_t           state_reg;
  logic [3:0]       digit_reg;
  logic             digit_valid_reg;
  logic             invalid_reg;
  logic             seq_error_reg;
  logic [CNT_W-1:0] digit_cnt_reg;
  logic [CNT_W-1:0] err_cnt_reg;

  logic [3:0] hex;
  logic       is_digit;
  logic       is_blank;
  logic       accept;

  seg7_to_hex u_dec (
    .seg      (s_q_reg),
    .hex      (hex),
    .is_digit (is_digit),
    .is_blank (is_blank)
  );

  always_comb begin
    stab_cnt_next = '0;
    if (s_q_reg == s_prev_reg) begin
      stab_cnt_next = (stab_cnt_reg == STAB_MAX) ? STAB_MAX
                                                  : stab_cnt_reg + STAB_W'(1);
    end
  end

  // Fire in the cycle the counter lands on its maximum so the registered
  // outputs update on that same edge; last_acc keeps a persisting pattern
  // from re-firing while the counter sits saturated.
  assign accept = (stab_cnt_next == STAB_MAX) && (s_q_reg != last_acc_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q_reg         <= SEG_BLANK;
      s_prev_reg      <= SEG_BLANK;
      stab_cnt_reg    <= '0;
      last_acc_reg    <= SEG_BLANK;
      state_reg       <= SYNC;
      digit_reg       <= 4'd0;
      digit_valid_reg <= 1'b0;
      invalid_reg     <= 1'b0;
      seq_error_reg   <= 1'b0;
      digit_cnt_reg   <= '0;
      err_cnt_reg     <= '0;
    end else begin
      s_q_reg         <= seg;
      s_prev_reg      <= s_q_reg;
      stab_cnt_reg    <= stab_cnt_next;
      digit_valid_reg <= 1'b0;
      invalid_reg     <= 1'b0;
      seq_error_reg   <= 1'b0;
      if (accept) begin
        last_acc_reg <= s_q_reg;
        if (is_digit) begin
          digit_reg       <= hex;
          digit_valid_reg <= 1'b1;
          if (digit_cnt_reg != '1) digit_cnt_reg <= digit_cnt_reg + CNT_W'(1);
          // Mismatch still resynchronises: the new digit becomes the
          // reference for the next check.
          if (state_reg == LOCKED && hex != next_digit(digit_reg)) begin
            seq_error_reg <= 1'b1;
            if (err_cnt_reg != '1) err_cnt_reg <= err_cnt_reg + CNT_W'(1);
          end
          state_reg <= LOCKED;
        end else if (is_blank) begin
          state_reg <= SYNC;
        end else begin
          invalid_reg <= 1'b1;
          state_reg   <= SYNC;
        end
      end
    end
  end

  assign digit       = digit_reg;
  assign digit_valid = digit_valid_reg;
  assign invalid     = invalid_reg;
  assign seq_error   = seq_error_reg;
  assign locked      = (state_reg == LOCKED);
  assign digit_cnt   = digit_cnt_reg;
  assign err_cnt     = err_cnt_reg;

endmodule
